// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive byte FIFO with CPU register port; optional rts_n hysteresis flow control under UART_RX_RTS_EN
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int RTS_HI = 12,
  parameter int RTS_LO = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_data_valid,
  output logic       rx_data_ready,
  input  logic       uart_cs,
  input  logic       R_W_n,
  input  logic [3:0] reg_addr,
  input  logic [7:0] data_i,
  output logic [7:0] data_o
`ifdef UART_RX_RTS_EN
  ,
  output logic       rts_n
`endif
);
  localparam logic [DEPTH_LOG2:0] DEPTH = (DEPTH_LOG2 + 1)'(2 ** DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0] CNT1 = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR1 = (DEPTH_LOG2)'(1);
  logic [7:0] mem [2 ** DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic [DEPTH_LOG2:0] count;
  logic overrun, rd_q, wr_q, rts_state;
  logic rd_sel, wr_sel, pop, push, flush, wr_pulse, ovr_set, full, not_empty;
  logic unused_data;
  assign rx_data_ready = 1'b1;
  assign unused_data = ^data_i[7:1];
  assign rd_sel = uart_cs & R_W_n & (reg_addr == 4'h0);
  assign wr_sel = uart_cs & ~R_W_n & (reg_addr == 4'h3);
  assign full = count == DEPTH;
  assign not_empty = count != '0;
  assign pop = rd_q & ~rd_sel & not_empty;
  assign push = rx_data_valid & (~full | pop);
  assign ovr_set = rx_data_valid & full & ~pop;
  assign wr_pulse = wr_sel & ~wr_q;
  assign flush = wr_pulse & data_i[0];
  // access-edge detectors: pop on the end of a head read, write acts on its first cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
    end else begin
      rd_q <= rd_sel;
      wr_q <= wr_sel;
    end
  // pointers, fill count and sticky overrun; flush overrides any push or pop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      overrun <= 1'b0;
    end else begin
      wptr <= flush ? '0 : push ? wptr + PTR1 : wptr;
      rptr <= flush ? '0 : pop ? rptr + PTR1 : rptr;
      count <= flush ? '0 : (push & ~pop) ? count + CNT1 : (pop & ~push) ? count - CNT1 : count;
      overrun <= ovr_set | (overrun & ~wr_pulse);
    end
  // storage array is not reset; the head read is gated while empty
  always_ff @(posedge clk)
    if (push & ~flush) mem[wptr] <= rx_data;
`ifdef UART_RX_RTS_EN
  localparam logic [DEPTH_LOG2:0] HI = (DEPTH_LOG2 + 1)'(RTS_HI);
  localparam logic [DEPTH_LOG2:0] LO = (DEPTH_LOG2 + 1)'(RTS_LO);
  // flow control with hysteresis: deassert near full, reassert once drained low
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rts_n <= 1'b0;
    else if (count >= HI) rts_n <= 1'b1;
    else if (count <= LO) rts_n <= 1'b0;
  assign rts_state = rts_n;
`else
  assign rts_state = 1'b0;
`endif
  // register read mux
  always_comb
    data_o = reg_addr == 4'h0 ? (not_empty ? mem[rptr] : 8'h00) :
             reg_addr == 4'h1 ? {4'b0, rts_state, overrun, full, not_empty} :
             reg_addr == 4'h2 ? 8'(count) : 8'h00;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: randomized and directed checks of uart_rx_fifo against a queue-based reference model
`timescale 1ns/1ps
module tb_uart_rx_fifo;
  localparam int D = 16, HI = 12, LO = 4;
`ifdef UART_RX_RTS_EN
  localparam bit RTS = 1'b1;
`else
  localparam bit RTS = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] rx_data = '0, data_i = '0, data_o;
  logic rx_data_valid = 1'b0, rx_data_ready, uart_cs = 1'b0, R_W_n = 1'b0;
  logic [3:0] reg_addr = '0;
`ifdef UART_RX_RTS_EN
  logic rts_n;
`endif
  int nvec = 0, nerr = 0, vp = 0;
  byte unsigned q[$];
  bit m_ovr = 0, m_rts = 0, prev_rd = 0, prev_wr = 0;

  always #5 clk = ~clk;

  uart_rx_fifo dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .rx_data_ready(rx_data_ready), .uart_cs(uart_cs), .R_W_n(R_W_n), .reg_addr(reg_addr),
    .data_i(data_i), .data_o(data_o)
`ifdef UART_RX_RTS_EN
    , .rts_n(rts_n)
`endif
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mread(input logic [3:0] a);
    if (a == 4'h0) return q.size() != 0 ? q[0] : 8'h00;
    if (a == 4'h1) return {4'b0, m_rts, m_ovr, q.size() == D, q.size() != 0};
    if (a == 4'h2) return 8'(q.size());
    return 8'h00;
  endfunction

  function automatic bit rv();
    return $urandom_range(99) < vp;
  endfunction

  function automatic logic [7:0] rb();
    return 8'($urandom_range(255));
  endfunction

  task automatic check_rts(input string tag, input bit exp);
`ifdef UART_RX_RTS_EN
    check(tag, {7'b0, rts_n}, {7'b0, exp});
`endif
  endtask

  // one clock cycle: drive, compare the addressed register, then advance the model across the edge
  task automatic step(input bit cs, input bit rw, input logic [3:0] a, input logic [7:0] d,
                      input bit v, input logic [7:0] b);
    int n;
    bit rd, pop, wst, acc;
    uart_cs = cs; R_W_n = rw; reg_addr = a; data_i = d; rx_data_valid = v; rx_data = b;
    #1;
    check($sformatf("data_o[%0h]", a), data_o, mread(a));
    check_rts("rts_n", m_rts);
    n = q.size();
    rd = cs && rw && a == 4'h0;
    pop = prev_rd && !rd && n > 0;
    wst = cs && !rw && a == 4'h3 && !prev_wr;
    acc = v && (n < D || pop);
    @(posedge clk);
    if (RTS) m_rts = n >= HI ? 1'b1 : n <= LO ? 1'b0 : m_rts;
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(b);
    if (wst) begin
      m_ovr = 1'b0;
      if (d[0]) q.delete();
    end
    if (v && !acc) m_ovr = 1'b1;
    prev_rd = rd;
    prev_wr = cs && !rw && a == 4'h3;
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    step(0, 0, 4'h0, 8'h00, 1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 4'h0, 8'h00, rv(), rb());
  endtask

  task automatic read_x(input logic [3:0] a, input int len, input bit v, input logic [7:0] b);
    for (int i = 0; i < len; i++) step(1, 1, a, rb(), rv(), rb());
    step(0, 0, 4'h0, 8'h00, v, b);
  endtask

  task automatic read_acc(input logic [3:0] a, input int len);
    read_x(a, len, rv(), rb());
  endtask

  task automatic write_acc(input logic [3:0] a, input logic [7:0] d, input int len);
    for (int i = 0; i < len; i++) step(1, 0, a, d, rv(), rb());
    step(0, 0, 4'h0, 8'h00, rv(), rb());
  endtask

  task automatic peek(input logic [3:0] a, input string tag, input logic [7:0] exp);
    uart_cs = 1'b0; reg_addr = a;
    #1;
    check(tag, data_o, exp);
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    reg_addr = 4'h1;
    #3;
    check("reset_status", data_o, 8'h00);
    reg_addr = 4'h2;
    #1;
    check("reset_count", data_o, 8'h00);
    check("rx_data_ready", {7'b0, rx_data_ready}, 8'h01);
    check_rts("reset_rts_n", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    vp = 0;
    push(8'h41); push(8'h42); push(8'h43);
    idle(1);
    peek(4'h2, "count_3", 8'h03);
    for (int i = 0; i < 3; i++) begin
      peek(4'h0, "head_abc", 8'(8'h41 + i));
      read_acc(4'h0, 4);
    end
    peek(4'h2, "count_0", 8'h00);
    peek(4'h1, "status_empty", 8'h00);
    for (int i = 0; i < 17; i++) push(8'(i));
    idle(1);
    peek(4'h2, "count_full", 8'h10);
    peek(4'h1, "status_overrun", RTS ? 8'h0F : 8'h07);
    for (int i = 0; i < 16; i++) begin
      peek(4'h0, "drain_head", 8'(i));
      read_acc(4'h0, 1 + i % 3);
    end
    idle(1);
    write_acc(4'h3, 8'h00, 2);
    peek(4'h1, "status_cleared", 8'h00);
    for (int i = 0; i < 16; i++) push(8'(8'h60 + i));
    read_x(4'h0, 2, 1'b1, 8'hAA);
    peek(4'h2, "count_push_pop_full", 8'h10);
    peek(4'h1, "status_no_overrun", RTS ? 8'h0B : 8'h03);
    for (int i = 0; i < 16; i++) read_acc(4'h0, 2);
    peek(4'h2, "count_after_drain", 8'h00);
    push(8'h55);
    read_x(4'h0, 1, 1'b1, 8'h66);
    peek(4'h0, "head_single_swap", 8'h66);
    read_acc(4'h0, 1);
    for (int i = 0; i < 40; i++) begin
      push(8'(8'h80 + i));
      if (i % 3 != 0) read_acc(4'h0, $urandom_range(1, 3));
    end
    while (q.size() != 0) read_acc(4'h0, 1);
`ifdef UART_RX_RTS_EN
    for (int i = 0; i < 12; i++) push(8'(i));
    idle(1);
    check_rts("rts_at_hi", 1'b1);
    for (int i = 0; i < 7; i++) read_acc(4'h0, 1);
    idle(1);
    check_rts("rts_at_5", 1'b1);
    read_acc(4'h0, 1);
    idle(1);
    check_rts("rts_at_lo", 1'b0);
    for (int i = 0; i < 4; i++) push(8'(i));
    write_acc(4'h3, 8'h01, 2);
    peek(4'h2, "count_flushed", 8'h00);
`endif
    vp = 40;
    for (int k = 0; k < 300; k++) begin
      int op;
      op = $urandom_range(9);
      if (op <= 4) read_acc(4'h0, $urandom_range(1, 4));
      else if (op == 5) read_acc(4'($urandom_range(1, 15)), $urandom_range(1, 3));
      else if (op == 6) write_acc(4'h3, rb(), $urandom_range(1, 3));
      else if (op == 7) write_acc(4'($urandom_range(15)), rb(), $urandom_range(1, 2));
      else idle($urandom_range(1, 4));
    end
    vp = 0;
    write_acc(4'h3, 8'h01, 1);
    for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
    step(1, 1, 4'h0, 8'h00, 1'b0, 8'h00);
    step(1, 1, 4'h0, 8'h00, 1'b0, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_head", data_o, 8'h00);
    reg_addr = 4'h2;
    #1;
    check("async_rst_count", data_o, 8'h00);
    check_rts("async_rst_rts_n", 1'b0);
    q.delete();
    m_ovr = 0; m_rts = 0; prev_rd = 0; prev_wr = 0;
    uart_cs = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    push(8'h99);
    read_acc(4'h0, 2);
    peek(4'h2, "count_after_reset_use", 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
